// File: rtl/four_source_rr_arbiter_pkg.sv
// Shared constants for the four-source round-robin arbiter and its one-hot mux.
// The one-hot select encodings are common to the arbiter and the mux.
package four_source_rr_arbiter_pkg;

  localparam int SRC_NUM = 4;

  localparam logic [SRC_NUM-1:0] SEL_NONE = 4'b0000;
  localparam logic [SRC_NUM-1:0] SEL_SRC0 = 4'b0001;
  localparam logic [SRC_NUM-1:0] SEL_SRC1 = 4'b0010;
  localparam logic [SRC_NUM-1:0] SEL_SRC2 = 4'b0100;
  localparam logic [SRC_NUM-1:0] SEL_SRC3 = 4'b1000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Index of a one-hot select; only meaningful when sel is non-zero.
  function automatic logic [1:0] sel_to_idx(input logic [SRC_NUM-1:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    case (sel)
      SEL_SRC1: idx = 2'd1;
      SEL_SRC2: idx = 2'd2;
      SEL_SRC3: idx = 2'd3;
      default:  idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/four_source_rr_arbiter_pick4.sv
// Rotate-priority picker: first set request scanning from rr_ptr upward, mod 4.
// Purely combinational; returns a one-hot winner and an any-request flag.
module rr_pick4
  import four_source_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic [3:0] winner,
  output logic       any
);

  logic [1:0] idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    winner = SEL_NONE;
    idx    = 2'd0;
    for (int k = SRC_NUM - 1; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (req[idx]) begin
        winner = 4'b0001 << idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/four_source_rr_arbiter.sv
// Round-robin burst arbiter driving the one-hot select of a four-input mux.
// Grant one cycle after request; holds for a burst; one idle bubble after release.
module four_source_rr_arbiter
  import four_source_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [3:0]       valid,
  input  logic [3:0]       last,
  input  logic             sink_ready,
  output logic [3:0]       sel,
  output logic             out_valid,
  output logic [3:0]       src_ready,
  output logic             busy
);

  state_t           state_q;
  logic [3:0]       sel_q;
  logic [1:0]       rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0] pick_winner;
  logic       pick_any;
  logic [1:0] gnt_idx;
  logic       xfer;
  logic       burst_end;
  logic       src_gone;
  logic       release_now;

  rr_pick4 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign gnt_idx   = sel_to_idx(sel_q);
  assign xfer      = (state_q == ST_GRANT) && valid[gnt_idx] && sink_ready;
  assign burst_end = last[gnt_idx] || (cnt_q == CNT_W'(MAX_BURST - 1));
  assign src_gone  = !req[gnt_idx] && !valid[gnt_idx];
  assign release_now = (state_q == ST_GRANT) && ((xfer && burst_end) || src_gone);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_NONE;
      rr_ptr_q <= 2'd0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            sel_q   <= pick_winner;
            cnt_q   <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            sel_q    <= SEL_NONE;
            rr_ptr_q <= gnt_idx + 2'd1;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
          end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          sel_q   <= SEL_NONE;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // sel_q is zero outside GRANT, so the handshake outputs fall to zero with it.
  assign sel       = sel_q;
  assign out_valid = |(sel_q & valid);
  assign src_ready = sel_q & {4{sink_ready}};
  assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_four_source_rr_arbiter.sv
// Directed bench for four_source_rr_arbiter with MAX_BURST=4.
module tb_four_source_rr_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] valid;
  logic [3:0] last;
  logic       sink_ready;
  logic [3:0] sel;
  logic       out_valid;
  logic [3:0] src_ready;
  logic       busy;

  int n_tests;
  int n_fail;

  four_source_rr_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .valid      (valid),
    .last       (last),
    .sink_ready (sink_ready),
    .sel        (sel),
    .out_valid  (out_valid),
    .src_ready  (src_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] valid;
    logic [3:0] last;
    logic       sr;
    logic [3:0] sel;
    logic       ov;
    logic [3:0] srdy;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] v, input logic [3:0] l,
                     input logic s, input logic [3:0] es, input logic eo,
                     input logic [3:0] er, input logic eb);
    vec_t t;
    t.req = r; t.valid = v; t.last = l; t.sr = s;
    t.sel = es; t.ov = eo; t.srdy = er; t.busy = eb;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got sel=%b ov=%b srdy=%b busy=%b, want sel=%b ov=%b srdy=%b busy=%b",
               name, got[9:6], got[5], got[4:1], got[0], exp[9:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [9:0] outs();
    return {sel, out_valid, src_ready, busy};
  endfunction

  logic [3:0] rr_order [10];

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Single source burst ending on last, with a last-without-valid cycle inside.
    add(4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 4'b0001, 1);
    add(4'b0001, 4'b0000, 4'b0001, 1, 4'b0001, 0, 4'b0001, 1);
    add(4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 1, 4'b0001, 1);
    add(4'b0001, 4'b0001, 4'b0001, 1, 4'b0001, 1, 4'b0001, 1);
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // Pointer moved to 1: source 1 beats source 0.
    add(4'b0011, 4'b0011, 4'b0011, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b0011, 4'b0011, 4'b0011, 1, 4'b0010, 1, 4'b0010, 1);
    // All requesting with single-word bursts: rotation with bubbles.
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b0100, 1, 4'b0100, 1);
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b1000, 1, 4'b1000, 1);
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 1);
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b1111, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0010, 1);
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // Source 2 streams without last: forced release after 4 words, then re-grant.
    add(4'b0100, 4'b0100, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    for (int i = 0; i < 4; i++)
      add(4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1);
    add(4'b0100, 4'b0100, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // Re-granted burst with sink_ready 1,0,0,1,1,1: release only on the 4th ready word.
    add(4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1);
    add(4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 1, 4'b0000, 1);
    add(4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 1, 4'b0000, 1);
    add(4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1);
    add(4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1);
    add(4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1);
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // Pointer at 3, only source 0 asks; foreign valid/last pulses are ignored.
    add(4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b0001, 4'b1111, 4'b1110, 1, 4'b0001, 1, 4'b0001, 1);
    add(4'b0000, 4'b0001, 4'b0000, 1, 4'b0001, 1, 4'b0001, 1);
    add(4'b1110, 4'b1110, 4'b1110, 1, 4'b0001, 0, 4'b0001, 1);
    add(4'b1110, 4'b1110, 4'b1110, 1, 4'b0000, 0, 4'b0000, 0);
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0010, 0, 4'b0010, 1);
    add(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);

    req = '0; valid = '0; last = '0; sink_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("reset_state", outs(), 10'b0);

    @(negedge clk);
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      req = vecs[i].req; valid = vecs[i].valid; last = vecs[i].last; sink_ready = vecs[i].sr;
      #1;
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].sel, vecs[i].ov, vecs[i].srdy, vecs[i].busy});
      @(negedge clk);
    end

    // Asynchronous reset mid-burst, then rotation restarts from source 0.
    req = 4'b0001; valid = 4'b0001; last = 4'b0000; sink_ready = 1'b1;
    @(negedge clk);
    #1;
    check("midburst_granted", outs(), {4'b0001, 1'b1, 4'b0001, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_clears", outs(), 10'b0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1111; valid = 4'b1111; last = 4'b1111;
    rr_order = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("rr_after_reset%0d", i), outs(),
            {rr_order[i], (rr_order[i] != 4'b0000), rr_order[i], (rr_order[i] != 4'b0000)});
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/four_source_rr_arbiter.md
# four_source_rr_arbiter

Round-robin arbiter that sits directly upstream of the 32-bit four-input one-hot mux. It owns the mux's 4-bit one-hot `sel` bus: it grants one of four word-stream sources at a time and holds the grant for a whole burst. It also drives the per-source ready and output-valid handshake around the mux's data path. Between grants `sel` is driven to 4'b0000, so the mux outputs zero.

## Interface
- `MAX_BURST`, default 16: maximum transfers per grant before forced release (2..255).
- `CNT_W`, default 8: width of the burst counter; must hold `MAX_BURST`.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `req` input 4: per-source request; bit i belongs to source i (mux input i+1).
- `valid` input 4: per-source word valid.
- `last` input 4: per-source end-of-burst marker; qualified by the matching `valid`.
- `sink_ready` input 1: downstream accepts the mux output this cycle.
- `sel` output 4: registered one-hot grant driven to the mux select (0001/0010/0100/1000), 0000 when idle.
- `out_valid` output 1: `valid` of the granted source; 0 when idle.
- `src_ready` output 4: `sel` ANDed with `sink_ready` in every bit.
- `busy` output 1: 1 in GRANT state.

## Operation
- States: IDLE and GRANT. Rotating pointer `rr_ptr` (2 bits). Burst counter `cnt` (`CNT_W` bits).
- **IDLE**
  - `sel`=0000.
  - If `req` is nonzero, pick the first set bit scanning `rr_ptr`, `rr_ptr`+1, … mod 4.
  - On the edge: load the one-hot of the winner into `sel`, clear `cnt`, and move to GRANT.
  - Otherwise hold.
- **GRANT** (granted index g)
  - A transfer is `valid[g]` & `sink_ready`. Each transfer increments `cnt`.
  - Release happens on the edge where any of these holds:
    - a transfer occurs with `last[g]`=1;
    - a transfer occurs with `cnt`==`MAX_BURST`-1, i.e. the MAX_BURST-th transfer;
    - `req[g]`=0 and `valid[g]`=0.
  - If several release conditions hold at once, a single release results.
  - On release: `sel` becomes 0000, `rr_ptr` becomes (g+1) mod 4, `cnt` is cleared, and the state returns to IDLE.
- `req`, `valid` and `last` of non-granted sources are ignored. `last[g]` without `valid[g]` is ignored.
- `sink_ready`=0 stalls: `cnt` holds and the grant is kept. `req[g]` dropping while `valid[g]`=1 does not release.
- `sel` is always one-hot or zero. No other encoding is ever driven, because the mux maps any other encoding to 0.

## Timing
- Reset (asynchronous, immediate): state IDLE, `sel`=0000, `rr_ptr`=0, `cnt`=0, `out_valid`=0, `src_ready`=0000, `busy`=0.
- Reset asserted mid-burst clears `sel` without waiting for a clock edge. The in-flight word is dropped; the source sees `src_ready` fall.
- Grant latency: `req` seen at edge N gives `sel` valid after edge N. The first transfer can happen in the cycle following edge N.
- One mandatory idle (bubble) cycle with `sel`=0000 follows every release, even when other requests are pending.
- `out_valid` and `src_ready` are combinational from registered `sel` plus the inputs. There is no combinational path from `req` to `sel`.
- `cnt` saturates by construction at `MAX_BURST`-1 before forced release and never wraps.

## Structure
- Shared include/package:
  - `SRC_NUM`=4;
  - one-hot constants `SEL_NONE`=4'b0000 and `SEL_SRC0`..`SEL_SRC3`=0001/0010/0100/1000, also used by the mux;
  - state encodings `ST_IDLE`/`ST_GRANT`.
- One sub-module, `rr_pick4`: combinational rotate-priority picker taking `req[3:0]` and `rr_ptr[1:0]`, returning a one-hot winner and an `any` flag. The FSM, counter, pointer and handshake logic live in the top.

## Test plan
- Reset, then `req`=0001 with `valid[0]`=1, `sink_ready`=1, and `last[0]` on the 3rd word → `sel`=0001 one cycle after `req`, 3 transfers, `sel`=0000 the next cycle, `rr_ptr`=1.
- `req`=1111 held continuously with single-word bursts → grant order 0001, 0010, 0100, 1000, 0001, each grant separated by one 0000 cycle.
- `MAX_BURST`=4, source 2 streaming with no `last` → exactly 4 transfers, forced release; re-granted after the bubble if it is the only requester.
- `sink_ready` toggled 1,0,0,1 during a grant → `cnt` advances only on ready cycles; `src_ready`=0000 while ready is low; grant is held.
- `reset_n` pulled low mid-burst between clock edges → `sel`, `out_valid` and `busy` go to 0 immediately; after release the first grant starts from source 0.
- Granted source drops `req` and `valid` together → release on the next edge; non-granted `valid`/`last` pulses during a grant never change `sel`.
